ucsbece154a_instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory writer: the inverse of the main/ALU decoders. It accepts field-level instruction requests over a valid/ready handshake, range-checks and packs them into 32-bit words for lw, sw, R-type, beq, I-type ALU, jal and lui, and writes them to consecutive instruction-memory addresses over an ack-based write port. It sits in the lab's program-load path ahead of the single-cycle core and produces the words the controller later decodes.

---
 rtl/ucsbece154a_instr_encoder_pkg.sv | 41 ++++
 rtl/ucsbece154a_instr_encoder_if.sv | 34 +++
 rtl/ucsbece154a_instr_pack.sv | 72 +++++++
 rtl/ucsbece154a_instr_encoder.sv | 124 ++++++++++++
 tb/tb_ucsbece154a_instr_encoder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucsbece154a_instr_encoder_pkg.sv
// rtl/ucsbece154a_instr_encoder_pkg.sv - shared constants and types for the RV32I instruction encoder
package ucsbece154a_instr_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_WRITE,
        ST_ERROR
    } state_t;

    localparam logic [31:0] BASE_RESET = 32'h0000_0000;

    localparam logic [2:0] CLS_LW  = 3'd0;
    localparam logic [2:0] CLS_SW  = 3'd1;
    localparam logic [2:0] CLS_R   = 3'd2;
    localparam logic [2:0] CLS_BEQ = 3'd3;
    localparam logic [2:0] CLS_I   = 3'd4;
    localparam logic [2:0] CLS_JAL = 3'd5;
    localparam logic [2:0] CLS_LUI = 3'd6;
    localparam logic [2:0] CLS_ILL = 3'd7;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_CLASS = 3'd1;
    localparam logic [2:0] ERR_RANGE = 3'd2;
    localparam logic [2:0] ERR_ALIGN = 3'd3;
    localparam logic [2:0] ERR_FUNCT = 3'd4;

    // Only the ALU ops the single-cycle core implements: add/sub, slt, or, and.
    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/ucsbece154a_instr_encoder_if.sv
// rtl/ucsbece154a_instr_encoder_if.sv - request, memory-write and status bundle of the encoder
interface ucsbece154a_instr_encoder_if;
    logic        load_base_i;
    logic [31:0] base_addr_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_class_i;
    logic [4:0]  req_rd_i;
    logic [4:0]  req_rs1_i;
    logic [4:0]  req_rs2_i;
    logic [2:0]  req_funct3_i;
    logic        req_sub_i;
    logic [31:0] req_imm_i;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wd_o;
    logic        imem_ack_i;
    logic        err_o;
    logic [2:0]  err_code_o;
    logic        clear_i;
    logic [15:0] words_o;

    modport slave (
        input  load_base_i, base_addr_i, req_valid_i, req_class_i, req_rd_i, req_rs1_i,
               req_rs2_i, req_funct3_i, req_sub_i, req_imm_i, imem_ack_i, clear_i,
        output req_ready_o, imem_we_o, imem_addr_o, imem_wd_o, err_o, err_code_o, words_o
    );

    modport master (
        output load_base_i, base_addr_i, req_valid_i, req_class_i, req_rd_i, req_rs1_i,
               req_rs2_i, req_funct3_i, req_sub_i, req_imm_i, imem_ack_i, clear_i,
        input  req_ready_o, imem_we_o, imem_addr_o, imem_wd_o, err_o, err_code_o, words_o
    );
endinterface

// File: rtl/ucsbece154a_instr_pack.sv
// rtl/ucsbece154a_instr_pack.sv - combinational field packer and legality checker
module ucsbece154a_instr_pack
    import ucsbece154a_instr_encoder_pkg::*;
(
    input  logic [2:0]  i_class,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_sub,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic [2:0]  o_err
);

    logic signed [31:0] w_simm;
    logic [2:0]         w_imm_err;
    logic               w_funct_bad;

    assign w_simm = i_imm;

    always_comb begin
        o_word    = '0;
        w_imm_err = ERR_NONE;
        case (i_class)
            CLS_LW: begin
                o_word = {i_imm[11:0], i_rs1, 3'b010, i_rd, OP_LW};
                if (w_simm < -32'sd2048 || w_simm > 32'sd2047) w_imm_err = ERR_RANGE;
            end
            CLS_SW: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OP_SW};
                if (w_simm < -32'sd2048 || w_simm > 32'sd2047) w_imm_err = ERR_RANGE;
            end
            CLS_R: begin
                o_word = {1'b0, i_sub, 5'b00000, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            end
            CLS_BEQ: begin
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b000, i_imm[4:1], i_imm[11], OP_BEQ};
                if (w_simm < -32'sd4096 || w_simm > 32'sd4094) w_imm_err = ERR_RANGE;
                else if (i_imm[0])                             w_imm_err = ERR_ALIGN;
            end
            CLS_I: begin
                o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
                if (w_simm < -32'sd2048 || w_simm > 32'sd2047) w_imm_err = ERR_RANGE;
            end
            CLS_JAL: begin
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
                if (w_simm < -32'sd1048576 || w_simm > 32'sd1048574) w_imm_err = ERR_RANGE;
                else if (i_imm[0])                                   w_imm_err = ERR_ALIGN;
            end
            CLS_LUI: begin
                o_word = {i_imm[31:12], i_rd, OP_LUI};
                if (i_imm[11:0] != 12'd0) w_imm_err = ERR_ALIGN;
            end
            default: begin
                o_word = '0;
            end
        endcase
    end

    // The sub bit only means something for R-type add; anywhere else it is a malformed request.
    assign w_funct_bad = (((i_class == CLS_R) || (i_class == CLS_I)) && !funct3_legal(i_funct3))
                       || (i_sub && !((i_class == CLS_R) && (i_funct3 == 3'b000)));

    always_comb begin
        o_err = ERR_NONE;
        if (i_class == CLS_ILL)  o_err = ERR_CLASS;
        else if (w_funct_bad)    o_err = ERR_FUNCT;
        else                     o_err = w_imm_err;
    end

endmodule

// File: rtl/ucsbece154a_instr_encoder.sv
// rtl/ucsbece154a_instr_encoder.sv - request FSM, field registers, write pointer and word counter
module ucsbece154a_instr_encoder
    import ucsbece154a_instr_encoder_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    ucsbece154a_instr_encoder_if.slave     bus
);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_class;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_funct3;
    logic        r_sub;
    logic [31:0] r_imm;
    logic [31:0] r_ptr;
    logic [31:0] r_wd;
    logic        r_err;
    logic [2:0]  r_code;
    logic [15:0] r_words;
    logic [31:0] w_word;
    logic [2:0]  w_pack_err;
    logic        w_ready;
    logic        w_hs;

    ucsbece154a_instr_pack u_pack (
        .i_class  (r_class),
        .i_rd     (r_rd),
        .i_rs1    (r_rs1),
        .i_rs2    (r_rs2),
        .i_funct3 (r_funct3),
        .i_sub    (r_sub),
        .i_imm    (r_imm),
        .o_word   (w_word),
        .o_err    (w_pack_err)
    );

    // Gated by reset so the block never advertises readiness while held in reset.
    assign w_ready = (r_state == ST_IDLE) && !reset;
    assign w_hs    = w_ready && bus.req_valid_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_hs) w_next = ST_ENCODE;
            ST_ENCODE: w_next = (w_pack_err == ERR_NONE) ? ST_WRITE : ST_ERROR;
            ST_WRITE:  if (bus.imem_ack_i) w_next = ST_IDLE;
            ST_ERROR:  if (bus.clear_i) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_class  <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_funct3 <= '0;
            r_sub    <= 1'b0;
            r_imm    <= '0;
            r_ptr    <= BASE_RESET;
            r_wd     <= '0;
            r_err    <= 1'b0;
            r_code   <= ERR_NONE;
            r_words  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.load_base_i) r_ptr <= bus.base_addr_i & 32'hFFFF_FFFC;
                    if (w_hs) begin
                        r_class  <= bus.req_class_i;
                        r_rd     <= bus.req_rd_i;
                        r_rs1    <= bus.req_rs1_i;
                        r_rs2    <= bus.req_rs2_i;
                        r_funct3 <= bus.req_funct3_i;
                        r_sub    <= bus.req_sub_i;
                        r_imm    <= bus.req_imm_i;
                    end
                end
                ST_ENCODE: begin
                    if (w_pack_err == ERR_NONE) begin
                        r_wd <= w_word;
                    end else begin
                        r_err  <= 1'b1;
                        r_code <= w_pack_err;
                    end
                end
                ST_WRITE: begin
                    if (bus.imem_ack_i) begin
                        r_ptr   <= r_ptr + 32'd4;
                        r_words <= r_words + 16'd1;
                    end
                end
                ST_ERROR: begin
                    if (bus.clear_i) begin
                        r_err  <= 1'b0;
                        r_code <= ERR_NONE;
                    end
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.imem_we_o   = (r_state == ST_WRITE);
    assign bus.imem_addr_o = r_ptr;
    assign bus.imem_wd_o   = r_wd;
    assign bus.err_o       = r_err;
    assign bus.err_code_o  = r_code;
    assign bus.words_o     = r_words;

endmodule

// File: tb/tb_ucsbece154a_instr_encoder.sv
// tb/tb_ucsbece154a_instr_encoder.sv - scoreboard bench with randomized requests and a reference encoder
module tb_ucsbece154a_instr_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ucsbece154a_instr_encoder_if bus ();

    ucsbece154a_instr_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_err;
        logic [2:0]  code;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] words;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_ptr;
    logic [15:0] m_words;
    logic        prev_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        logic [31:0] mask;
        mask = (32'd1 << (hi - lo + 1)) - 32'd1;
        return (v >> lo) & mask;
    endfunction

    // Reference encoder: legality from integer ranges, word from ISA bit placement.
    function automatic void model(input int cls, input int rd, input int rs1, input int rs2,
                                  input int f3, input int sub, input logic [31:0] imm,
                                  output int code, output logic [31:0] word);
        longint v;
        bit     f3ok;
        v    = longint'($signed(imm));
        f3ok = (f3 == 0) || (f3 == 2) || (f3 == 6) || (f3 == 7);
        code = 0;
        word = 32'd0;
        if (cls == 7) code = 1;
        else if (((cls == 2 || cls == 4) && !f3ok) || (sub != 0 && !(cls == 2 && f3 == 0))) code = 4;
        else if (cls == 0 || cls == 1 || cls == 4) begin
            if (v < -2048 || v > 2047) code = 2;
        end else if (cls == 3) begin
            if (v < -4096 || v > 4094) code = 2;
            else if (v % 2 != 0)       code = 3;
        end else if (cls == 5) begin
            if (v < -1048576 || v > 1048574) code = 2;
            else if (v % 2 != 0)             code = 3;
        end else if (cls == 6) begin
            if (imm % 4096 != 0) code = 3;
        end
        case (cls)
            0: word = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
            1: word = (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                    | (fld(imm, 4, 0) << 7) | 32'h23;
            2: word = (sub << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            3: word = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
                    | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
            4: word = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            5: word = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
                    | (fld(imm, 19, 12) << 12) | (rd << 7) | 32'h6F;
            6: word = (imm & 32'hFFFF_F000) | (rd << 7) | 32'h37;
            default: word = 32'd0;
        endcase
    endfunction

    task automatic do_req(input int cls, input int rd, input int rs1, input int rs2, input int f3,
                          input int sub, input logic [31:0] imm, input bit ld, input logic [31:0] base,
                          input int stall, input bit use_want, input logic [31:0] want);
        int          code;
        logic [31:0] word;
        logic [31:0] a;
        logic [31:0] d;
        exp_t        e;
        bit          done;
        int          t;
        t = 0;
        @(negedge clk);
        while (bus.req_ready_o !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("ready_wait");
        bus.req_class_i  = 3'(cls);
        bus.req_rd_i     = 5'(rd);
        bus.req_rs1_i    = 5'(rs1);
        bus.req_rs2_i    = 5'(rs2);
        bus.req_funct3_i = 3'(f3);
        bus.req_sub_i    = 1'(sub);
        bus.req_imm_i    = imm;
        bus.load_base_i  = ld;
        bus.base_addr_i  = base;
        bus.req_valid_i  = 1'b1;
        model(cls, rd, rs1, rs2, f3, sub, imm, code, word);
        if (ld) m_ptr = {base[31:2], 2'b00};
        e.is_err = (code != 0);
        e.code   = 3'(code);
        e.addr   = m_ptr;
        e.data   = use_want ? want : word;
        e.words  = m_words;
        if (code == 0) begin
            m_ptr   = m_ptr + 32'd4;
            m_words = m_words + 16'd1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.load_base_i = 1'b0;
        bus.imem_ack_i  = (stall == 0);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.imem_we_o === 1'b1) begin
                if (stall > 0) begin
                    a = bus.imem_addr_o;
                    d = bus.imem_wd_o;
                    for (int s = 0; s < stall; s++) begin
                        @(negedge clk);
                        check("stall_we", 32'(bus.imem_we_o), 32'd1);
                        check("stall_addr", bus.imem_addr_o, a);
                        check("stall_data", bus.imem_wd_o, d);
                        check("stall_ready", 32'(bus.req_ready_o), 32'd0);
                    end
                    @(posedge clk);
                    #1 bus.imem_ack_i = 1'b1;
                    @(negedge clk);
                end
                @(posedge clk);
                #1 bus.imem_ack_i = 1'b0;
                done = 1'b1;
            end else if (bus.err_o === 1'b1) begin
                @(posedge clk);
                #1 bus.clear_i = 1'b1;
                bus.imem_ack_i = 1'b0;
                @(posedge clk);
                #1 bus.clear_i = 1'b0;
                check("clear_err", 32'(bus.err_o), 32'd0);
                check("clear_code", 32'(bus.err_code_o), 32'd0);
                done = 1'b1;
            end
        end
        if (!done) timeout("write_or_error");
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (bus.imem_we_o === 1'b1 && bus.imem_ack_i === 1'b1) begin
                if (sb.size() == 0) timeout("unexpected_write");
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("write_expected", 32'(e.is_err), 32'd0);
                    check("write_addr", bus.imem_addr_o, e.addr);
                    check("write_data", bus.imem_wd_o, e.data);
                    check("words_before", 32'(bus.words_o), 32'(e.words));
                end
            end
            if (bus.err_o === 1'b1 && prev_err !== 1'b1) begin
                if (sb.size() == 0) timeout("unexpected_error");
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("error_expected", 32'(e.is_err), 32'd1);
                    check("err_code", 32'(bus.err_code_o), 32'(e.code));
                    check("err_no_we", 32'(bus.imem_we_o), 32'd0);
                    check("err_words", 32'(bus.words_o), 32'(e.words));
                end
            end
        end
        prev_err <= bus.err_o;
    end

    logic signed [31:0] edges [16];

    initial begin
        int cls;
        int f3;
        logic [31:0] imm;
        edges = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097, 1048574, 1048575,
                  1048576, -1048576, -1048578, 32'sh1234_5000, 32'shABCD_E000};
        reset            = 1'b1;
        bus.load_base_i  = 1'b0;
        bus.base_addr_i  = '0;
        bus.req_valid_i  = 1'b0;
        bus.req_class_i  = '0;
        bus.req_rd_i     = '0;
        bus.req_rs1_i    = '0;
        bus.req_rs2_i    = '0;
        bus.req_funct3_i = '0;
        bus.req_sub_i    = 1'b0;
        bus.req_imm_i    = '0;
        bus.imem_ack_i   = 1'b0;
        bus.clear_i      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_we", 32'(bus.imem_we_o), 32'd0);
        check("rst_addr", bus.imem_addr_o, 32'h0);
        check("rst_wd", bus.imem_wd_o, 32'h0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_code", 32'(bus.err_code_o), 32'd0);
        check("rst_words", 32'(bus.words_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_ptr   = 32'h0;
        m_words = 16'd0;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.req_ready_o), 32'd1);

        do_req(4, 1, 0, 0, 0, 0, 32'd5, 0, 0, 0, 1, 32'h0050_0093);
        do_req(2, 3, 1, 2, 0, 1, 32'd0, 0, 0, 1, 1, 32'h4020_81B3);
        do_req(3, 0, 1, 2, 0, 0, -32'sd8, 0, 0, 0, 1, 32'hFE20_8CE3);
        do_req(5, 1, 0, 0, 0, 0, 32'h800, 0, 0, 0, 1, 32'h0010_00EF);
        do_req(6, 5, 0, 0, 0, 0, 32'h1234_5000, 0, 0, 3, 1, 32'h1234_52B7);
        do_req(3, 0, 1, 2, 0, 0, 32'd5, 0, 0, 0, 0, 0);
        do_req(4, 2, 3, 0, 0, 1, 32'd1, 0, 0, 0, 0, 0);
        do_req(0, 4, 2, 0, 0, 0, 32'd16, 0, 0, 0, 0, 0);
        do_req(1, 0, 2, 7, 0, 0, -32'sd4, 1, 32'hFFFF_FFFF, 1, 0, 0);
        do_req(4, 6, 6, 0, 7, 0, -32'sd2048, 0, 0, 0, 0, 0);
        do_req(7, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0);
        do_req(0, 1, 1, 0, 0, 0, 32'd0, 1, 32'h0000_0103, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            cls = $urandom_range(0, 7);
            f3  = ($urandom_range(0, 1) == 0) ? 2 * $urandom_range(0, 1) + 4 * ($urandom_range(0, 3) == 0)
                                              : $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0:       imm = 32'($urandom_range(0, 40)) - 32'd20;
                1:       imm = edges[$urandom_range(0, 15)];
                2:       imm = $urandom & 32'hFFFF_F000;
                default: imm = $urandom;
            endcase
            do_req(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), f3,
                   ($urandom_range(0, 7) == 0) ? 1 : 0, imm, ($urandom_range(0, 9) == 0),
                   $urandom, $urandom_range(0, 2), 0, 0);
        end

        // Reset while a word is pending in WRITE: the strobe must drop without a clock edge.
        @(negedge clk);
        bus.req_class_i  = 3'd0;
        bus.req_imm_i    = 32'd8;
        bus.req_sub_i    = 1'b0;
        bus.req_valid_i  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        bus.imem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_we", 32'(bus.imem_we_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_we", 32'(bus.imem_we_o), 32'd0);
        check("async_reset_ready", 32'(bus.req_ready_o), 32'd0);
        check("async_reset_addr", bus.imem_addr_o, 32'h0);
        check("async_reset_words", 32'(bus.words_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_ptr   = 32'h0;
        m_words = 16'd0;
        do_req(4, 9, 8, 0, 6, 0, 32'd100, 0, 0, 0, 0, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
